// File: rtl/fcpu_cdb_arbiter.sv
// Round-robin arbiter for the common data bus. It picks at most one completed
// functional-unit result per cycle and drives it onto a registered CDB broadcast.
module fcpu_cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*TAG_W-1:0]    req_tag,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [$clog2(N_REQ)-1:0]  cdb_src
);

  localparam int SRC_W = $clog2(N_REQ);

  // Handshake: requester i transfers at a rising edge when req_valid[i] & req_ready[i].
  // req_ready is a pure function of req_valid, ptr_q, flush and rst_n, and is never
  // asserted toward a requester that is not valid, so every grant is a transfer.
  // The CDB side has no backpressure: cdb_valid is a one-cycle broadcast.

  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [SRC_W-1:0]  cdb_src_q;

  logic              grant_vld;
  logic [SRC_W-1:0]  grant_idx;
  logic [SRC_W:0]    scan_idx;
  logic [SRC_W-1:0]  scan_sel;

  // One extra bit on scan_idx holds ptr+k (at most 2*N_REQ-2) before wrapping,
  // so non-power-of-two N_REQ wraps at N_REQ and not at 2**SRC_W.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    scan_sel  = '0;
    if (rst_n && !flush) begin
      for (int k = 0; k < N_REQ; k++) begin
        scan_idx = {1'b0, ptr_q} + (SRC_W+1)'(k);
        if (scan_idx >= (SRC_W+1)'(N_REQ)) begin
          scan_idx = scan_idx - (SRC_W+1)'(N_REQ);
        end
        scan_sel = scan_idx[SRC_W-1:0];
        if (!grant_vld && req_valid[scan_sel]) begin
          grant_vld = 1'b1;
          grant_idx = scan_sel;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cdb_valid_q <= grant_vld;
      if (grant_vld) begin
        cdb_tag_q  <= req_tag[grant_idx*TAG_W +: TAG_W];
        cdb_data_q <= req_data[grant_idx*DATA_W +: DATA_W];
        cdb_src_q  <= grant_idx;
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_fcpu_cdb_arbiter.sv
// Bench for fcpu_cdb_arbiter: a behavioural round-robin model predicts grants,
// and the expected CDB broadcasts are queued and compared one cycle later.
module tb_fcpu_cdb_arbiter;

  localparam int N_REQ  = 4;
  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;
  localparam int SRC_W  = 2;
  localparam int EW     = SRC_W + TAG_W + DATA_W;

  logic                    clk;
  logic                    rst_n;
  logic                    flush;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*TAG_W-1:0]  req_tag;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;
  logic [SRC_W-1:0]        cdb_src;

  logic              v  [N_REQ];
  logic [TAG_W-1:0]  tg [N_REQ];
  logic [DATA_W-1:0] dt [N_REQ];

  logic [EW-1:0] exp_q[$];
  int m_ptr;
  int last_g;
  int n_tests;
  int n_fail;
  int src_seen[8];

  fcpu_cdb_arbiter #(.N_REQ(N_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_valid[i]                = v[i];
      req_tag[i*TAG_W +: TAG_W]   = tg[i];
      req_data[i*DATA_W +: DATA_W] = dt[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_grant();
    if (!rst_n || flush) return -1;
    for (int k = 0; k < N_REQ; k++) begin
      if (v[(m_ptr + k) % N_REQ]) return (m_ptr + k) % N_REQ;
    end
    return -1;
  endfunction

  // One clock: check ready against the model, then the CDB after the edge.
  task automatic cycle();
    int g;
    logic [N_REQ-1:0] er;
    logic [EW-1:0] e;
    #1;
    g  = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(er));
    if (g >= 0) begin
      exp_q.push_back({SRC_W'(g), tg[g], dt[g]});
      m_ptr = (g + 1) % N_REQ;
    end
    last_g = g;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cdb_valid", 64'(cdb_valid), 64'd1);
      check("cdb_payload", 64'({cdb_src, cdb_tag, cdb_data}), 64'(e));
    end else begin
      check("cdb_idle", 64'(cdb_valid), 64'd0);
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N_REQ; i++) v[i] = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_ptr   = 0;
    last_g  = -1;
    flush   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      v[i] = 1'b0; tg[i] = '0; dt[i] = '0;
    end

    // reset then idle
    rst_n = 1'b0;
    #2;
    check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("rst_cdb_fields", 64'({cdb_src, cdb_tag, cdb_data}), 64'd0);
    for (int c = 0; c < 3; c++) cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) cycle();

    // single request on unit 2
    v[2] = 1'b1; tg[2] = 5'h0A; dt[2] = 32'hDEADBEEF;
    #1;
    check("single_ready", 64'(req_ready), 64'b0100);
    cycle();
    check("single_tag", 64'(cdb_tag), 64'h0A);
    check("single_data", 64'(cdb_data), 64'hDEADBEEF);
    check("single_src", 64'(cdb_src), 64'd2);
    v[2] = 1'b0;
    cycle();

    // unit 3 once so the pointer returns to 0
    v[3] = 1'b1; tg[3] = 5'h1F; dt[3] = 32'h3333_0000;
    cycle();
    v[3] = 1'b0;

    // round robin, all valid continuously
    for (int i = 0; i < N_REQ; i++) begin
      v[i] = 1'b1; tg[i] = TAG_W'(i + 1); dt[i] = 32'hA000_0000 + DATA_W'(i);
    end
    for (int c = 0; c < 8; c++) begin
      cycle();
      src_seen[c] = int'(cdb_src);
      check("rr_tag", 64'(cdb_tag), 64'((c % 4) + 1));
      check("rr_no_bubble", 64'(cdb_valid), 64'd1);
    end
    clear_reqs();

    // fairness after skip: pointer at 1, only units 0 and 3
    v[0] = 1'b1; tg[0] = 5'h10; dt[0] = 32'h0000_1000;
    cycle();
    v[3] = 1'b1; tg[3] = 5'h13; dt[3] = 32'h0000_3000;
    cycle();
    check("fair_first", 64'(cdb_src), 64'd3);
    cycle();
    check("fair_second", 64'(cdb_src), 64'd0);
    cycle();
    check("fair_third", 64'(cdb_src), 64'd3);
    clear_reqs();

    // flush kills arbitration for one cycle
    v[1] = 1'b1; tg[1] = 5'h11; dt[1] = 32'hF1F1_F1F1;
    flush = 1'b1;
    #1;
    check("flush_ready", 64'(req_ready), 64'd0);
    cycle();
    check("flush_cdb", 64'(cdb_valid), 64'd0);
    flush = 1'b0;
    cycle();
    check("after_flush_src", 64'(cdb_src), 64'd1);
    clear_reqs();

    // async reset mid-stream
    for (int i = 0; i < N_REQ; i++) begin
      v[i] = 1'b1; tg[i] = TAG_W'(i + 8); dt[i] = 32'hB000_0000 + DATA_W'(i);
    end
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_cdb_valid", 64'(cdb_valid), 64'd0);
    check("async_ready", 64'(req_ready), 64'd0);
    exp_q.delete();
    m_ptr = 0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    check("post_rst_src", 64'(cdb_src), 64'd0);
    clear_reqs();
    cycle();

    // random traffic with holding requesters and occasional flush
    for (int c = 0; c < 300; c++) begin
      flush = ($urandom_range(0, 7) == 0);
      cycle();
      if (last_g >= 0) v[last_g] = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i]  = 1'b1;
          tg[i] = TAG_W'($urandom_range(0, 31));
          dt[i] = $urandom;
        end
      end
    end
    flush = 1'b0;
    clear_reqs();
    cycle();
    check("drain_queue", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
